// File: rtl/alu_req_driver.sv
// alu_req_driver: valid/ready front end that drives the combinational ALU bus and returns its result.
// Optional build macro ALU_REQ_DRIVER_STATS_EN adds saturating handshake / error counters.

module alu_req_driver #(
    parameter int n   = 32,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_op,
    input  logic [n-1:0] req_a,
    input  logic [n-1:0] req_b,
    input  logic         req_signed,
    output logic [3:0]   alu_s,
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    output logic         alu_sign,
    input  logic [n-1:0] alu_z,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [n-1:0] rsp_z,
    output logic         rsp_err,
    output logic         busy
`ifdef ALU_REQ_DRIVER_STATS_EN
    ,
    output logic [15:0]  stat_ops,
    output logic [15:0]  stat_errs
`endif
);

    localparam int         SHW    = $clog2(n);
    localparam logic [3:0] LAT_C  = 4'(LAT);
    localparam logic [3:0] OP_DIV = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t         state_q;
    logic [3:0]     cnt_q;
    logic           req_ready_q;
    logic           busy_q;
    logic [3:0]     alu_s_q;
    logic [n-1:0]   alu_a_q;
    logic [n-1:0]   alu_b_q;
    logic           alu_sign_q;
    logic           rsp_valid_q;
    logic [n-1:0]   rsp_z_q;
    logic           rsp_err_q;

    logic           op_legal_d;
    logic           div_zero_d;
    logic [n-1:0]   b_drive_d;

    // Request decode: legality, divide-by-zero, and shift-amount wrap modulo n.
    always_comb begin
        op_legal_d = (req_op <= OP_NOT);
        div_zero_d = (req_op == OP_DIV) && (req_b == {n{1'b0}});
        if ((req_op == OP_SLL) || (req_op == OP_SRL)) begin
            b_drive_d = {{(n-SHW){1'b0}}, req_b[SHW-1:0]};
        end else begin
            b_drive_d = req_b;
        end
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            alu_s_q     <= 4'd0;
            alu_a_q     <= {n{1'b0}};
            alu_b_q     <= {n{1'b0}};
            alu_sign_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_z_q     <= {n{1'b0}};
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    alu_s_q    <= 4'd0;
                    alu_a_q    <= {n{1'b0}};
                    alu_b_q    <= {n{1'b0}};
                    alu_sign_q <= 1'b0;
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (!op_legal_d) begin
                            rsp_z_q     <= {n{1'b0}};
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else if (div_zero_d) begin
                            rsp_z_q     <= {n{1'b1}};
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            alu_s_q    <= req_op;
                            alu_a_q    <= req_a;
                            alu_b_q    <= b_drive_d;
                            alu_sign_q <= req_signed;
                            cnt_q      <= LAT_C;
                            state_q    <= DRIVE;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                DRIVE: begin
                    // Bus has been stable for LAT cycles on the cnt==1 edge, so Z is settled.
                    if (cnt_q == 4'd1) begin
                        rsp_z_q     <= alu_z;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        alu_s_q     <= 4'd0;
                        alu_a_q     <= {n{1'b0}};
                        alu_b_q     <= {n{1'b0}};
                        alu_sign_q  <= 1'b0;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        rsp_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign alu_s     = alu_s_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sign  = alu_sign_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_err   = rsp_err_q;

`ifdef ALU_REQ_DRIVER_STATS_EN
    logic [15:0] stat_ops_q;
    logic [15:0] stat_errs_q;

    // Saturating counters stepped on each response handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops_q  <= 16'd0;
            stat_errs_q <= 16'd0;
        end else if ((state_q == RESP) && rsp_ready) begin
            if (stat_ops_q != 16'hFFFF) begin
                stat_ops_q <= stat_ops_q + 16'd1;
            end
            if (rsp_err_q && (stat_errs_q != 16'hFFFF)) begin
                stat_errs_q <= stat_errs_q + 16'd1;
            end
        end
    end

    assign stat_ops  = stat_ops_q;
    assign stat_errs = stat_errs_q;
`endif

endmodule

// File: tb/tb_alu_req_driver.sv
// Bench for alu_req_driver: three instances (LAT=1,3,4), each with a directed sequence, randomized
// traffic, an environment ALU and a transaction-level reference model compared every cycle.

module tb_alu_req_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int lat, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s lat=%0d t=%0t got=%h want=%h", nm, lat, $time, act, exp);
        end
    endtask

    // Result the ALU must deliver for a request, straight from the opcode table.
    function automatic logic [31:0] ref_z(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
        logic [31:0] r;
        r = 32'd0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a + b;
            4'd3: r = a - b;
            4'd4: r = a * b;
            4'd5: begin
                if (b == 32'd0)                      r = 32'd0;
                else if (s && (b == 32'hFFFF_FFFF))  r = 32'd0 - a;
                else if (s)                          r = $signed(a) / $signed(b);
                else                                 r = a / b;
            end
            4'd6: r = a << (b % 32'd32);
            4'd7: r = a >> (b % 32'd32);
            4'd8: r = ~a;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_lat
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);

        logic        rst, req_valid, req_ready, req_signed;
        logic [3:0]  req_op, alu_s;
        logic [31:0] req_a, req_b, alu_a, alu_b, alu_z, rsp_z;
        logic        alu_sign, rsp_valid, rsp_ready, rsp_err, busy;
`ifdef ALU_REQ_DRIVER_STATS_EN
        logic [15:0] stat_ops, stat_errs;
`endif
        bit fin = 1'b0;

        alu_req_driver #(.n(32), .LAT(L)) dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
            .req_a(req_a), .req_b(req_b), .req_signed(req_signed),
            .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_sign(alu_sign), .alu_z(alu_z),
            .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z), .rsp_err(rsp_err),
            .busy(busy)
`ifdef ALU_REQ_DRIVER_STATS_EN
            , .stat_ops(stat_ops), .stat_errs(stat_errs)
`endif
        );

        // Environment ALU: acts on the bus exactly as driven (shift amounts are not re-masked here).
        always_comb begin
            alu_z = 32'd0;
            case (alu_s)
                4'd0: alu_z = alu_a & alu_b;
                4'd1: alu_z = alu_a | alu_b;
                4'd2: alu_z = alu_a + alu_b;
                4'd3: alu_z = alu_a - alu_b;
                4'd4: alu_z = alu_a * alu_b;
                4'd5: begin
                    if (alu_b == 32'd0)                             alu_z = 32'd0;
                    else if (alu_sign && (alu_b == 32'hFFFF_FFFF))  alu_z = 32'd0 - alu_a;
                    else if (alu_sign)                              alu_z = $signed(alu_a) / $signed(alu_b);
                    else                                            alu_z = alu_a / alu_b;
                end
                4'd6: alu_z = alu_a << alu_b;
                4'd7: alu_z = alu_a >> alu_b;
                4'd8: alu_z = ~alu_a;
                default: alu_z = 32'd0;
            endcase
        end

        // Reference model: a pending transaction described by its accept edge and derived windows.
        initial begin : model
            int e, bus_end, rsp_start, sops, serrs;
            bit m_in, m_rdy, m_legal, eerr, es, drv, rv;
            logic [3:0]  eop;
            logic [31:0] ea, eb, ez;
            e = 0; bus_end = 0; rsp_start = 0; sops = 0; serrs = 0;
            m_in = 0; m_rdy = 0; m_legal = 0; eerr = 0; es = 0;
            eop = 4'd0; ea = 32'd0; eb = 32'd0; ez = 32'd0;
            forever begin
                @(posedge clk);
                e++;
                if (rst) begin
                    m_in = 0; m_rdy = 0; sops = 0; serrs = 0;
                end else if (!m_in) begin
                    if (req_valid && m_rdy) begin
                        m_in = 1; m_rdy = 0;
                        eop = req_op; ea = req_a; es = req_signed;
                        eb = ((req_op == 4'd6) || (req_op == 4'd7)) ? (req_b % 32'd32) : req_b;
                        if (req_op > 4'd8) begin
                            m_legal = 0; ez = 32'd0; eerr = 1; rsp_start = e;
                        end else if ((req_op == 4'd5) && (req_b == 32'd0)) begin
                            m_legal = 0; ez = 32'hFFFF_FFFF; eerr = 1; rsp_start = e;
                        end else begin
                            m_legal = 1; ez = ref_z(req_op, req_a, req_b, req_signed); eerr = 0;
                            bus_end = e + L - 1; rsp_start = e + L;
                        end
                    end else begin
                        m_rdy = 1;
                    end
                end else if ((e - 1 >= rsp_start) && rsp_ready) begin
                    m_in = 0; m_rdy = 1;
                    if (sops < 65535) sops++;
                    if (eerr && (serrs < 65535)) serrs++;
                end
                @(negedge clk);
                drv = m_in && m_legal && (e <= bus_end);
                rv  = m_in && (e >= rsp_start);
                chk("req_ready", L, 32'(req_ready), 32'(m_rdy));
                chk("busy", L, 32'(busy), 32'(m_in));
                chk("rsp_valid", L, 32'(rsp_valid), 32'(rv));
                chk("alu_s", L, 32'(alu_s), drv ? 32'(eop) : 32'd0);
                chk("alu_a", L, alu_a, drv ? ea : 32'd0);
                chk("alu_b", L, alu_b, drv ? eb : 32'd0);
                chk("alu_sign", L, 32'(alu_sign), drv ? 32'(es) : 32'd0);
                if (rv) begin
                    chk("rsp_z", L, rsp_z, ez);
                    chk("rsp_err", L, 32'(rsp_err), 32'(eerr));
                end
`ifdef ALU_REQ_DRIVER_STATS_EN
                chk("stat_ops", L, 32'(stat_ops), 32'(sops));
                chk("stat_errs", L, 32'(stat_errs), 32'(serrs));
`endif
            end
        end

        task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input int rr_low, output logic [31:0] z,
                            output logic err, output logic [3:0] bs, output logic [31:0] bb);
            int k;
            req_op = op; req_a = a; req_b = b; req_signed = s; req_valid = 1'b1;
            rsp_ready = (rr_low == 0);
            k = 0;
            while ((req_ready !== 1'b1) && (k < 20)) begin @(negedge clk); k++; end
            if (k >= 20) chk("acc_wait", L, 32'(req_ready), 32'd1);
            @(negedge clk);
            req_valid = 1'b0;
            bs = alu_s; bb = alu_b;
            k = 0;
            while ((rsp_valid !== 1'b1) && (k < 40)) begin @(negedge clk); k++; end
            if (k >= 40) chk("rsp_wait", L, 32'(rsp_valid), 32'd1);
            z = rsp_z; err = rsp_err;
            repeat (rr_low) @(negedge clk);
            rsp_ready = 1'b1;
            @(negedge clk);
        endtask

        // Directed sequence followed by randomized traffic.
        initial begin : stim
            logic [31:0] z, bb;
            logic [3:0]  bs;
            logic        err;
            bit          seen;
            rst = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_a = 32'd0; req_b = 32'd0;
            req_signed = 1'b0; rsp_ready = 1'b0;
            repeat (2) @(negedge clk);
            chk("rst_ready", L, 32'(req_ready), 32'd0);
            chk("rst_busy", L, 32'(busy), 32'd0);
            chk("rst_rsp_z", L, rsp_z, 32'd0);
            rst = 1'b0;
            @(negedge clk);
            chk("ready_after_rst", L, 32'(req_ready), 32'd1);

            // Abort: reset lands two edges after acceptance.
            req_op = 4'd2; req_a = 32'd9; req_b = 32'd9; req_valid = 1'b1;
            @(negedge clk);
            req_valid = 1'b0; seen = rsp_valid;
            @(negedge clk);
            seen |= rsp_valid; rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            repeat (8) begin @(negedge clk); seen |= rsp_valid; end
            chk("mid_rst_rsp", L, 32'(seen), (L == 1) ? 32'd1 : 32'd0);
            chk("mid_rst_busy", L, 32'(busy), 32'd0);
`ifdef ALU_REQ_DRIVER_STATS_EN
            chk("mid_rst_stat", L, 32'(stat_ops), 32'd0);
`endif
            send(4'b0010, 32'd5, 32'd7, 1'b0, 0, z, err, bs, bb);
            chk("add_z", L, z, 32'd12);
            chk("add_err", L, 32'(err), 32'd0);
            chk("add_bus_s", L, 32'(bs), 32'd2);
            send(4'b0011, 32'd10, 32'd3, 1'b0, 4, z, err, bs, bb);
            chk("sub_z", L, z, 32'd7);
            send(4'b0101, 32'd123, 32'd0, 1'b0, 0, z, err, bs, bb);
            chk("div0_z", L, z, 32'hFFFF_FFFF);
            chk("div0_err", L, 32'(err), 32'd1);
            chk("div0_bus_s", L, 32'(bs), 32'd0);
            send(4'b1011, 32'd1, 32'd2, 1'b0, 0, z, err, bs, bb);
            chk("illegal_z", L, z, 32'd0);
            chk("illegal_err", L, 32'(err), 32'd1);
            send(4'b0110, 32'd1, 32'd33, 1'b0, 0, z, err, bs, bb);
            chk("sll_bus_b", L, bb, 32'd1);
            chk("sll_z", L, z, 32'd2);
`ifdef ALU_REQ_DRIVER_STATS_EN
            chk("stat_ops_dir", L, 32'(stat_ops), 32'd5);
            chk("stat_errs_dir", L, 32'(stat_errs), 32'd2);
`endif
            for (int i = 0; i < 1500; i++) begin
                rst        = ($urandom_range(0, 249) == 0);
                req_valid  = ($urandom_range(0, 2) != 0);
                req_op     = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(9, 15))
                                                         : 4'($urandom_range(0, 8));
                req_a      = $urandom;
                req_b      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                req_signed = 1'($urandom_range(0, 1));
                rsp_ready  = ($urandom_range(0, 3) != 0);
                @(negedge clk);
            end
            rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
            repeat (20) @(negedge clk);
            fin = 1'b1;
        end
    end

    initial begin : finisher
        int k;
        k = 0;
        while (!(g_lat[0].fin && g_lat[1].fin && g_lat[2].fin) && (k < 20000)) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20000) begin
            chk("finish_wait", 0, {29'd0, g_lat[2].fin, g_lat[1].fin, g_lat[0].fin}, 32'd7);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
